sid_i2c_writer: RTL and testbench
=================================

Name: sid_i2c_writer

Overview:
I2C master (write-only) that drives the SID chip's I2C register port from a host-side controller or test harness. It accepts one register write (reg address plus data byte) over a valid/ready handshake. It then generates START, address byte, reg byte, data byte and STOP on open-drain SCL/SDA, and checks each ACK. It is the initiator counterpart of the chip's I2C register slave at 7-bit address 0x36 (registers 0..6).

Parameters:
CLK_DIV, 125, clk cycles per quarter bit-period (≥1); bit period = 4*CLK_DIV clk cycles.
DEV_ADDR, 7'h36, 7-bit target address; address byte on wire = {DEV_ADDR,1'b0} = 0x6C.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
wr_valid  in  1  write request
wr_ready  out  1  high only in IDLE; transfer accepted when wr_valid&&wr_ready at a clk edge
wr_reg  in  8  register address, captured on accept
wr_data  in  8  data byte, captured on accept
sda_in  in  1  SDA line sense (ACK sampling)
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_oe  out  1  1 = pull SCL low, 0 = release
done  out  1  one-cycle pulse at transaction end (success or NACK)
nack  out  1  status: 1 if last transaction aborted on NACK; cleared on next accept
busy  out  1  ~wr_ready

Behaviour:
- Reset (any cycle, including mid-transfer): state=IDLE, sda_oe=0, scl_oe=0, done=0, nack=0, wr_ready=1, quarter counter=0, bit/byte counters=0. Lines are released on the cycle after the reset edge. No STOP is generated.
- Accept at edge T: latch wr_reg/wr_data, clear nack, enter START. START q0 occupies cycles T+1..T+CLK_DIV.
- Timing base: a divider counts 0..CLK_DIV-1 and advances the quarter index q0→q1→q2→q3→(next bit).
- States: IDLE, START, BIT, ACK, STOP.
- START (1 bit-period):
  - q0: SCL rel, SDA rel.
  - q1: SCL rel, SDA low (START condition).
  - q2: SCL rel, SDA low.
  - q3: SCL low, SDA low.
- BIT (8 per byte, MSB first):
  - q0: SCL low; SDA = bit (0 → oe=1, 1 → rel).
  - q1, q2: SCL rel, SDA held.
  - q3: SCL low, SDA held.
  - SDA changes only while SCL is low.
- ACK (1 bit-period after each byte):
  - SDA released throughout; SCL pattern as BIT.
  - sda_in sampled on the first clk of q2.
  - 0 → ACK: next byte, or STOP after byte index 2.
  - 1 → NACK: set nack, go to STOP after ACK q3; remaining bytes are skipped.
- Byte order: index 0 = 0x6C, 1 = wr_reg, 2 = wr_data.
- STOP (1 bit-period):
  - q0: SCL low, SDA low.
  - q1: SCL rel, SDA low.
  - q2: SCL rel, SDA rel (STOP condition).
  - q3: both rel.
  - done=1 on the final clk of STOP q3; the next cycle is IDLE with wr_ready=1.
- Latency:
  - Full transaction = (1+27+1)*4*CLK_DIV = 116*CLK_DIV cycles; done at T+116*CLK_DIV.
  - NACK at byte k (0..2): done at T+(2+9*(k+1))*4*CLK_DIV.
- wr_valid while busy: ignored, no effect on the transfer. Back-to-back requests: earliest accept is the cycle after done.
- No clock stretching and no arbitration; scl_in is not sensed. The slave's SDA is assumed low only in ACK slots.
- Outputs are registered; done/nack change only on clk edges.

Test Plan:
- CLK_DIV=2, write reg 0x06 data 0x41, slave model ACKs all → wire bytes 0x6C,0x06,0x41 decoded on SCL rising; done at T+232; nack=0; SDA never toggles while SCL high except at START/STOP.
- CLK_DIV=2, slave NACKs the address byte (sda_in=1 in first ACK) → STOP follows directly, no further SCL pulses, done at T+88, nack=1; next accepted write clears nack.
- CLK_DIV=1, write reg 0x01 data 0xFF with ACKs; loop-back into the chip's I2C slave → slave frequency high byte reads 0xFF, and done at T+116.
- wr_valid held high continuously with changing wr_reg/wr_data mid-transfer → only the values at accept edges are sent; a second transfer starts at done+1 with its START q0.
- Assert rst at cycle 50 of a transfer → sda_oe=scl_oe=0 and wr_ready=1 the next cycle, done never pulses; a subsequent write completes normally.
- Idle check: 1000 cycles with wr_valid=0 → sda_oe=scl_oe=0 and done=0 throughout.

Source files
------------

// File: rtl/sid_i2c_writer_if.sv
// Host-side write request handshake plus the open-drain I2C line controls
// of the SID register-port writer. The host/harness uses the master modport,
// the writer itself uses the slave modport.
interface sid_i2c_writer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       sda_in;
    logic       sda_oe;
    logic       scl_oe;
    logic       done;
    logic       nack;
    logic       busy;

    modport master (
        output wr_valid, wr_reg, wr_data, sda_in,
        input  wr_ready, sda_oe, scl_oe, done, nack, busy
    );

    modport slave (
        input  wr_valid, wr_reg, wr_data, sda_in,
        output wr_ready, sda_oe, scl_oe, done, nack, busy
    );
endinterface

// File: rtl/sid_i2c_writer.sv
// Write-only I2C master for the SID register port. One accepted request
// produces START, address byte, register byte, data byte and STOP, with the
// ACK of every byte checked. A NACK skips the remaining bytes and goes
// straight to STOP. Each bit period is four quarters of CLK_DIV clocks.
module sid_i2c_writer #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h36
) (
    input logic              clk,
    input logic              rst,
    sid_i2c_writer_if.slave  bus
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_ACK   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // Current position on the wire
    state_t           state_r;
    logic [1:0]       q_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_r;
    logic [1:0]       byte_r;

    // Captured request and ACK status
    logic [7:0]       reg_r;
    logic [7:0]       data_r;
    logic             ack_bad_r;

    // Registered outputs
    logic             wr_ready_r;
    logic             busy_r;
    logic             sda_oe_r;
    logic             scl_oe_r;
    logic             done_r;
    logic             nack_r;

    // Next position on the wire
    state_t           state_s;
    logic [1:0]       q_s;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_s;
    logic [1:0]       byte_s;

    logic             accept_s;
    logic             quarter_end_s;
    logic             ack_sample_s;
    logic [7:0]       tx_byte_s;
    logic             tx_bit_s;
    logic             sda_oe_s;
    logic             scl_oe_s;
    logic             done_s;

    assign accept_s      = (state_r == S_IDLE) && bus.wr_valid;
    assign quarter_end_s = (cnt_r == CNT_LAST);
    // The slave's ACK is looked at once, on the first clock of ACK q2,
    // i.e. well inside the SCL-high window.
    assign ack_sample_s  = (state_r == S_ACK) && (q_r == 2'd2) &&
                           (cnt_r == {CNT_W{1'b0}});

    // Advance the quarter divider and walk START -> bytes/ACKs -> STOP
    always_comb begin
        state_s = state_r;
        q_s     = q_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        if (state_r == S_IDLE) begin
            if (bus.wr_valid) begin
                state_s = S_START;
                q_s     = 2'd0;
                cnt_s   = {CNT_W{1'b0}};
                bit_s   = 3'd0;
                byte_s  = 2'd0;
            end else begin
                state_s = S_IDLE;
            end
        end else if (!quarter_end_s) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else if (q_r != 2'd3) begin
            cnt_s = {CNT_W{1'b0}};
            q_s   = q_r + 2'd1;
        end else begin
            cnt_s = {CNT_W{1'b0}};
            q_s   = 2'd0;
            case (state_r)
                S_START: begin
                    state_s = S_BIT;
                    bit_s   = 3'd0;
                    byte_s  = 2'd0;
                end
                S_BIT: begin
                    if (bit_r == 3'd7) begin
                        state_s = S_ACK;
                        bit_s   = 3'd0;
                    end else begin
                        bit_s   = bit_r + 3'd1;
                    end
                end
                S_ACK: begin
                    if (ack_bad_r || (byte_r == 2'd2)) begin
                        state_s = S_STOP;
                    end else begin
                        state_s = S_BIT;
                        byte_s  = byte_r + 2'd1;
                        bit_s   = 3'd0;
                    end
                end
                S_STOP: begin
                    state_s = S_IDLE;
                    bit_s   = 3'd0;
                    byte_s  = 2'd0;
                end
                default: begin
                    state_s = S_IDLE;
                    bit_s   = 3'd0;
                    byte_s  = 2'd0;
                end
            endcase
        end
    end

    // Select the byte being shifted out and its current bit, MSB first
    always_comb begin
        case (byte_s)
            2'd0:    tx_byte_s = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte_s = reg_r;
            2'd2:    tx_byte_s = data_r;
            default: tx_byte_s = 8'h00;
        endcase
        tx_bit_s = tx_byte_s[3'd7 - bit_s];
    end

    // Line drive for the upcoming cycle; SDA only moves while SCL is low,
    // except for the deliberate START and STOP edges
    always_comb begin
        sda_oe_s = 1'b0;
        scl_oe_s = 1'b0;
        case (state_s)
            S_IDLE: begin
                sda_oe_s = 1'b0;
                scl_oe_s = 1'b0;
            end
            S_START: begin
                sda_oe_s = (q_s != 2'd0);
                scl_oe_s = (q_s == 2'd3);
            end
            S_BIT: begin
                sda_oe_s = ~tx_bit_s;
                scl_oe_s = (q_s == 2'd0) || (q_s == 2'd3);
            end
            S_ACK: begin
                sda_oe_s = 1'b0;
                scl_oe_s = (q_s == 2'd0) || (q_s == 2'd3);
            end
            S_STOP: begin
                sda_oe_s = (q_s == 2'd0) || (q_s == 2'd1);
                scl_oe_s = (q_s == 2'd0);
            end
            default: begin
                sda_oe_s = 1'b0;
                scl_oe_s = 1'b0;
            end
        endcase
        done_s = (state_s == S_STOP) && (q_s == 2'd3) && (cnt_s == CNT_LAST);
    end

    // State, request capture, ACK status and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            q_r        <= 2'd0;
            cnt_r      <= {CNT_W{1'b0}};
            bit_r      <= 3'd0;
            byte_r     <= 2'd0;
            reg_r      <= 8'h00;
            data_r     <= 8'h00;
            ack_bad_r  <= 1'b0;
            wr_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            sda_oe_r   <= 1'b0;
            scl_oe_r   <= 1'b0;
            done_r     <= 1'b0;
            nack_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            q_r        <= q_s;
            cnt_r      <= cnt_s;
            bit_r      <= bit_s;
            byte_r     <= byte_s;
            wr_ready_r <= (state_s == S_IDLE);
            busy_r     <= (state_s != S_IDLE);
            sda_oe_r   <= sda_oe_s;
            scl_oe_r   <= scl_oe_s;
            done_r     <= done_s;
            if (accept_s) begin
                reg_r     <= bus.wr_reg;
                data_r    <= bus.wr_data;
                ack_bad_r <= 1'b0;
                nack_r    <= 1'b0;
            end else if (ack_sample_s) begin
                ack_bad_r <= bus.sda_in;
                nack_r    <= nack_r | bus.sda_in;
            end else begin
                ack_bad_r <= ack_bad_r;
                nack_r    <= nack_r;
            end
        end
    end

    assign bus.wr_ready = wr_ready_r;
    assign bus.busy     = busy_r;
    assign bus.sda_oe   = sda_oe_r;
    assign bus.scl_oe   = scl_oe_r;
    assign bus.done     = done_r;
    assign bus.nack     = nack_r;

endmodule

// File: tb/tb_sid_i2c_writer.sv
// Bench for sid_i2c_writer: an open-drain bus model with an I2C slave that
// ACKs or NACKs chosen bytes, decoding everything seen on SCL rising edges.
module tb_sid_i2c_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sid_i2c_writer_if bus2 ();
    sid_i2c_writer_if bus1 ();

    sid_i2c_writer #(.CLK_DIV(2), .DEV_ADDR(7'h36)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sid_i2c_writer #(.CLK_DIV(1), .DEV_ADDR(7'h36)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- bus + slave model ----------------
    logic       slave_pull = 1'b0;
    logic       scl_w, sda_w;
    logic       scl_p = 1'b1, sda_p = 1'b1;
    logic       in_frame = 1'b0;
    int         bitcnt = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] got[$];
    int         start_cnt = 0, stop_cnt = 0, scl_rises = 0;
    int         nack_abs = -1;

    assign scl_w       = ~bus2.scl_oe;
    assign sda_w       = ~bus2.sda_oe & ~slave_pull;
    assign bus2.sda_in = sda_w;
    assign bus1.sda_in = 1'b0;

    // Decode START/STOP/bits and drive the slave ACK slot
    always @(negedge clk) begin
        scl_p <= scl_w;
        sda_p <= sda_w;
        if (rst) begin
            in_frame   <= 1'b0;
            slave_pull <= 1'b0;
            bitcnt     <= 0;
        end else if (scl_p && scl_w && sda_p && !sda_w) begin
            start_cnt  <= start_cnt + 1;
            in_frame   <= 1'b1;
            bitcnt     <= 0;
            slave_pull <= 1'b0;
        end else if (scl_p && scl_w && !sda_p && sda_w) begin
            stop_cnt   <= stop_cnt + 1;
            in_frame   <= 1'b0;
        end else if (!scl_p && scl_w) begin
            scl_rises <= scl_rises + 1;
            if (in_frame) begin
                if (bitcnt < 8) shreg <= {shreg[6:0], sda_w};
                if (bitcnt == 8) begin
                    got.push_back(shreg);
                    bitcnt <= 0;
                end else begin
                    bitcnt <= bitcnt + 1;
                end
            end
        end else if (scl_p && !scl_w && in_frame) begin
            slave_pull <= (bitcnt == 8) && (got.size() != nack_abs);
        end
    end

    // ---------------- reference model ----------------
    function automatic int model_nbytes(input int k);
        return (k < 0) ? 3 : k + 1;
    endfunction

    function automatic int model_lat(input int k, input int cd);
        return (2 + 9 * model_nbytes(k)) * 4 * cd;
    endfunction

    function automatic logic [7:0] model_byte(input int i, input logic [7:0] r, input logic [7:0] d);
        if (i == 0) return 8'h6C;
        else if (i == 1) return r;
        else return d;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // One complete write on dut2; k = index of NACKed byte, -1 for none
    task automatic run_write(input logic [7:0] r, input logic [7:0] d, input int k,
                             input int exp_lat, input int exp_nack);
        int base, rise0, st0, sp0, lat, nb, n;
        base  = got.size();
        rise0 = scl_rises;
        st0   = start_cnt;
        sp0   = stop_cnt;
        nack_abs = (k < 0) ? -1 : base + k;
        @(negedge clk);
        n = 0;
        while (!bus2.wr_ready && n < 3000) begin @(negedge clk); n++; end
        bus2.wr_valid = 1'b1;
        bus2.wr_reg   = r;
        bus2.wr_data  = d;
        @(posedge clk);
        @(negedge clk);
        bus2.wr_valid = 1'b0;
        lat = 1;
        chk("accept_nack_clr_busy", {bus2.nack, bus2.busy}, 2'b01);
        while (!bus2.done && lat < 3000) begin @(negedge clk); lat++; end
        chk("done_latency", lat, exp_lat);
        chk("nack_status", bus2.nack, exp_nack);
        @(negedge clk);
        chk("done_pulse_then_ready", {bus2.done, bus2.wr_ready}, 2'b01);
        nb = model_nbytes(k);
        chk("byte_count", got.size() - base, nb);
        for (int i = 0; i < nb; i++)
            if (base + i < got.size()) chk("wire_byte", got[base + i], model_byte(i, r, d));
        chk("scl_pulses", scl_rises - rise0, 9 * nb + 1);
        chk("start_stop", (start_cnt - st0) * 10 + (stop_cnt - sp0), 11);
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         k;
        int         exp_nack;
        int         exp_lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n, viol;
        logic [7:0] rr, dd;
        int kk;

        vecs[0] = '{r: 8'h06, d: 8'h41, k: -1, exp_nack: 0, exp_lat: 232};
        vecs[1] = '{r: 8'h00, d: 8'h00, k:  0, exp_nack: 1, exp_lat: 88};
        vecs[2] = '{r: 8'h12, d: 8'h34, k:  1, exp_nack: 1, exp_lat: 160};
        vecs[3] = '{r: 8'hA5, d: 8'h5A, k:  2, exp_nack: 1, exp_lat: 232};
        vecs[4] = '{r: 8'hFF, d: 8'h80, k: -1, exp_nack: 0, exp_lat: 232};

        bus2.wr_valid = 1'b0; bus2.wr_reg = 8'h00; bus2.wr_data = 8'h00;
        bus1.wr_valid = 1'b0; bus1.wr_reg = 8'h00; bus1.wr_data = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {bus2.sda_oe, bus2.scl_oe, bus2.done, bus2.nack, bus2.wr_ready, bus2.busy}, 6'b000010);
        rst = 1'b0;

        // Idle: lines released, no done
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus2.sda_oe || bus2.scl_oe || bus2.done || !bus2.wr_ready) viol++;
        end
        chk("idle_quiet", viol, 0);

        // Directed table
        for (int i = 0; i < 5; i++)
            run_write(vecs[i].r, vecs[i].d, vecs[i].k, vecs[i].exp_lat, vecs[i].exp_nack);

        // Randomised writes against the model
        for (int i = 0; i < 6; i++) begin
            rr = 8'($urandom_range(0, 255));
            dd = 8'($urandom_range(0, 255));
            kk = int'($urandom_range(0, 3)) - 1;
            run_write(rr, dd, kk, model_lat(kk, 2), (kk < 0) ? 0 : 1);
        end

        // wr_valid held high with request fields changing mid-transfer
        begin
            int base;
            base = got.size();
            nack_abs = -1;
            @(negedge clk);
            bus2.wr_valid = 1'b1; bus2.wr_reg = 8'h3C; bus2.wr_data = 8'hC3;
            @(posedge clk);
            n = 0;
            do begin
                @(negedge clk); n++;
                if (!bus2.wr_ready) begin
                    bus2.wr_reg  = 8'($urandom_range(0, 255));
                    bus2.wr_data = 8'($urandom_range(0, 255));
                end
            end while (!bus2.wr_ready && n < 3000);
            chk("hold_ready_cycle", n, 233);
            bus2.wr_reg = 8'h5A; bus2.wr_data = 8'h99;
            @(posedge clk);
            @(negedge clk);
            chk("hold_second_start", bus2.busy, 1);
            n = 1;
            while (!bus2.done && n < 3000) begin
                bus2.wr_reg  = 8'($urandom_range(0, 255));
                bus2.wr_data = 8'($urandom_range(0, 255));
                @(negedge clk); n++;
            end
            bus2.wr_valid = 1'b0;
            chk("hold_second_latency", n, 232);
            chk("hold_byte_count", got.size() - base, 6);
            if (got.size() - base == 6) begin
                chk("hold_b1", got[base + 1], 8'h3C);
                chk("hold_b2", got[base + 2], 8'hC3);
                chk("hold_b4", got[base + 4], 8'h5A);
                chk("hold_b5", got[base + 5], 8'h99);
            end
            @(negedge clk);
        end

        // Reset mid-transfer
        nack_abs = -1;
        @(negedge clk);
        bus2.wr_valid = 1'b1; bus2.wr_reg = 8'h02; bus2.wr_data = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus2.wr_valid = 1'b0;
        repeat (49) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_release", {bus2.sda_oe, bus2.scl_oe, bus2.wr_ready, bus2.done}, 4'b0010);
        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus2.done || bus2.sda_oe || bus2.scl_oe) viol++;
        end
        chk("midreset_no_done", viol, 0);
        run_write(8'h05, 8'h3E, -1, 232, 0);

        // CLK_DIV=1 instance: full write latency
        @(negedge clk);
        bus1.wr_valid = 1'b1; bus1.wr_reg = 8'h01; bus1.wr_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        bus1.wr_valid = 1'b0;
        n = 1;
        while (!bus1.done && n < 3000) begin @(negedge clk); n++; end
        chk("div1_latency", n, 116);
        chk("div1_nack", bus1.nack, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
